fdc_sd_arbiter: RTL and testbench
=================================

Name: fdc_sd_arbiter

Overview:
- Shares one MiSTer SD block-level port between the four per-drive wd1793 instances in the floppy controller.
- Uses round-robin arbitration: it grants one drive, latches that drive's LBA and direction, drives the single sd_rd/sd_wr, and routes sd_ack and buffer traffic back to the granted drive only.
- Sits between the fdc drive array and hps_io, so the top level needs only one SD virtual-disk channel.

Parameters:
- NUM_REQ, 4, number of requesting drives; valid range 2..4.
- TIMEOUT_CYCLES, 16777216, CLK cycles allowed from issue to sd_ack rise (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high reset.
- req_rd  input  NUM_REQ  per-drive block read request (level).
- req_wr  input  NUM_REQ  per-drive block write request (level).
- req_lba  input  32xNUM_REQ  per-drive LBA.
- req_ack  output  NUM_REQ  per-drive ack; copy of sd_ack for the granted drive only.
- req_buff_wr  output  NUM_REQ  sd_buff_wr routed to the granted drive only.
- req_buff_din  input  8xNUM_REQ  per-drive write-buffer read data.
- sd_lba  output  32  latched LBA of the granted drive.
- sd_rd  output  1  block read request to hps_io.
- sd_wr  output  1  block write request to hps_io.
- sd_ack  input  1  hps_io acknowledge.
- sd_buff_wr  input  1  hps_io buffer write strobe.
- sd_buff_din  output  8  req_buff_din of the granted drive; 0 when idle.
- busy  output  1  high in every state except IDLE.
- grant  output  2  index of the current or last granted drive.
- timeout  output  1  one-cycle pulse on watchdog abort (optional feature; tied 0 otherwise).

Behaviour:
- Reset values: req_ack=0, req_buff_wr=0, sd_lba=0, sd_rd=0, sd_wr=0, sd_buff_din=0, busy=0, grant=0, timeout=0. The round-robin pointer resets to 0 and the FSM to IDLE. Reset during any state aborts immediately with no completion signalled.
- FSM states: IDLE, ISSUE, XFER, DONE.
- IDLE:
  - A drive is pending if req_rd[i] | req_wr[i].
  - Search starts at the pointer and wraps modulo NUM_REQ; the first pending drive wins.
  - On a win, in the same edge: grant<=i, sd_lba<=req_lba[i], dir<=req_wr[i]; go to ISSUE.
  - If a drive has both rd and wr high, write wins.
- ISSUE: sd_rd=~dir, sd_wr=dir (registered, first asserted one cycle after grant). On sd_ack=1, drop sd_rd/sd_wr on the same edge and go to XFER.
- XFER:
  - req_ack[grant]=sd_ack and req_buff_wr[grant]=sd_buff_wr, combinational pass-through with zero latency.
  - sd_buff_din = req_buff_din[grant] combinationally in all non-IDLE states.
  - On sd_ack=0, go to DONE.
- DONE: one cycle; pointer<=grant+1 (wraps at NUM_REQ); go to IDLE. Minimum gap between consecutive grants is one idle cycle.
- Routing to non-granted drives: req_ack and req_buff_wr are 0 for every non-granted index in all states.
- Request withdrawn after grant: the transfer still completes on the latched LBA/dir; ack is still routed to the granted drive.
- sd_ack high while in IDLE: ignored and not routed.
- A request re-asserted by the same drive waits behind the other pending drives (fairness): with all four requesting, the grant order is 0,1,2,3,0.
- Worst-case wait is NUM_REQ-1 transfers.

Optional Feature:
- FDC_ARB_TIMEOUT_EN defined: a counter runs in ISSUE. If TIMEOUT_CYCLES elapse with no sd_ack:
  - sd_rd/sd_wr drop, timeout pulses for one cycle, and the FSM goes to DONE (pointer advances).
  - The drive gets no ack, and its own wd1793 timeout handles the failure.
  - The counter clears on entry to ISSUE.
- Undefined: no counter; ISSUE waits indefinitely; timeout tied 0.

Decomposition:
- Package fdc_pkg:
  - arb_state_t enum (IDLE, ISSUE, XFER, DONE).
  - FDC_NUM_DRIVES=4.
  - SD_LBA_W=32.
  - Default TIMEOUT_CYCLES constant.
- Sub-module rr_pick: combinational round-robin priority picker (pending vector, pointer → index, valid). Reusable by other arbiters.

Test Plan:
- Single read: req_rd[2]=1, req_lba[2]=0x00000123.
  - Expect grant=2, sd_lba=0x123, and sd_rd rising two cycles after the request.
  - Hold sd_ack for 256 buff_wr strobes: only req_buff_wr[2] toggles, and req_ack[2] mirrors sd_ack.
  - After ack falls: busy=0 two cycles later.
- All four rd requests asserted together and held: grants occur in order 0,1,2,3,0. The pointer after drive 3 wraps to 0.
- Write path: req_wr[1]=1 with req_buff_din[1]=0xA5 and req_buff_din[0]=0x5A. Expect sd_wr=1, sd_rd=0, and sd_buff_din=0xA5 throughout.
- Both req_rd[0] and req_wr[0] high: sd_wr asserts and sd_rd stays 0.
- Reset mid-XFER: RESET pulsed while sd_ack=1. All outputs read 0 immediately (asynchronous), and the FSM returns to IDLE with grant=0.
- With FDC_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=100: never assert sd_ack. Expect sd_rd to drop after 100 cycles, a one-cycle timeout pulse, and the pending drive 3 granted next.

Source files
------------

// File: rtl/fdc_pkg.sv
// Shared types and constants for the floppy controller SD-port arbiter.
// Build option: define FDC_ARB_TIMEOUT_EN to enable the ISSUE-state watchdog.
package fdc_pkg;

    localparam int FDC_NUM_DRIVES     = 4;
    localparam int SD_LBA_W           = 32;
    localparam int GRANT_W            = 2;
    localparam int FDC_TIMEOUT_CYCLES = 16777216;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        DONE
    } arb_state_t;

endpackage

// File: rtl/fdc_sd_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] pending_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    int cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int off = 0; off < N; off++) begin
            cand = (int'(ptr_i) + off) % N;
            if (!valid_o && pending_i[W'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = W'(cand);
            end
        end
    end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Round-robin arbiter sharing one hps_io SD block port between the wd1793 drives.
// Build option: define FDC_ARB_TIMEOUT_EN to enable the ISSUE-state watchdog.
module fdc_sd_arbiter
    import fdc_pkg::*;
#(
    parameter int NUM_REQ        = FDC_NUM_DRIVES,
    parameter int TIMEOUT_CYCLES = FDC_TIMEOUT_CYCLES
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [NUM_REQ-1:0]                req_rd,
    input  logic [NUM_REQ-1:0]                req_wr,
    input  logic [NUM_REQ-1:0][SD_LBA_W-1:0]  req_lba,
    output logic [NUM_REQ-1:0]                req_ack,
    output logic [NUM_REQ-1:0]                req_buff_wr,
    input  logic [NUM_REQ-1:0][7:0]           req_buff_din,
    output logic [SD_LBA_W-1:0]               sd_lba,
    output logic                              sd_rd,
    output logic                              sd_wr,
    input  logic                              sd_ack,
    input  logic                              sd_buff_wr,
    output logic [7:0]                        sd_buff_din,
    output logic                              busy,
    output logic [GRANT_W-1:0]                grant,
    output logic                              timeout
);

    arb_state_t          state_q, state_d;
    logic [GRANT_W-1:0]  ptr_q, ptr_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [SD_LBA_W-1:0] lba_q, lba_d;
    logic                dir_q, dir_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [GRANT_W-1:0]  pick_idx;
    logic                pick_valid;
    logic                to_expired;

    rr_pick #(
        .N (NUM_REQ),
        .W (GRANT_W)
    ) u_pick (
        .pending_i (req_rd | req_wr),
        .ptr_i     (ptr_q),
        .idx_o     (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        lba_d   = lba_q;
        dir_d   = dir_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    lba_d   = req_lba[pick_idx];
                    dir_d   = req_wr[pick_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    state_d = XFER;
                end else if (to_expired) begin
                    state_d = DONE;
                end else begin
                    rd_d = ~dir_q;
                    wr_d = dir_q;
                end
            end
            XFER: begin
                if (!sd_ack) state_d = DONE;
            end
            DONE: begin
                ptr_d   = (grant_q == GRANT_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            lba_q   <= '0;
            dir_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            lba_q   <= lba_d;
            dir_q   <= dir_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    // Ack and buffer strobes reach only the granted drive, with no added latency.
    always_comb begin
        req_ack     = '0;
        req_buff_wr = '0;
        sd_buff_din = '0;
        if (state_q != IDLE) begin
            req_ack[grant_q]     = sd_ack;
            req_buff_wr[grant_q] = sd_buff_wr;
            sd_buff_din          = req_buff_din[grant_q];
        end
    end

    assign sd_lba = lba_q;
    assign sd_rd  = rd_q;
    assign sd_wr  = wr_q;
    assign busy   = (state_q != IDLE);
    assign grant  = grant_q;

`ifdef FDC_ARB_TIMEOUT_EN
    logic [31:0] cnt_q;
    logic        timeout_q;

    // Counter is zero on the first ISSUE cycle because it is held clear elsewhere.
    assign to_expired = (state_q == ISSUE) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= (state_q == ISSUE) ? cnt_q + 32'd1 : '0;
            timeout_q <= to_expired && !sd_ack;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;

    assign to_expired         = 1'b0;
    assign timeout            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Self-checking bench for fdc_sd_arbiter: directed cases plus randomized
// round-robin traffic checked against a rule-level model.
module tb_fdc_sd_arbiter;
    import fdc_pkg::*;

    localparam int N          = 4;
    localparam int TB_TIMEOUT = 100;

    logic               CLK = 1'b0;
    logic               RESET;
    logic [N-1:0]       req_rd, req_wr, req_ack, req_buff_wr;
    logic [N-1:0][31:0] req_lba;
    logic [N-1:0][7:0]  req_buff_din;
    logic [31:0]        sd_lba;
    logic               sd_rd, sd_wr, sd_ack, sd_buff_wr;
    logic [7:0]         sd_buff_din;
    logic               busy;
    logic [1:0]         grant;
    logic               timeout;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    fdc_sd_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .req_rd       (req_rd),
        .req_wr       (req_wr),
        .req_lba      (req_lba),
        .req_ack      (req_ack),
        .req_buff_wr  (req_buff_wr),
        .req_buff_din (req_buff_din),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .sd_buff_wr   (sd_buff_wr),
        .sd_buff_din  (sd_buff_din),
        .busy         (busy),
        .grant        (grant),
        .timeout      (timeout)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Spec rule: scan from the pointer, wrapping, first pending drive wins.
    function automatic int model_pick(input logic [N-1:0] pend, input int ptr);
        for (int k = 0; k < N; k++)
            if (pend[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"},  64'(req_ack),     64'd0);
        check({tag, "_bwr"},  64'(req_buff_wr), 64'd0);
        check({tag, "_lba"},  64'(sd_lba),      64'd0);
        check({tag, "_rdwr"}, 64'({sd_rd, sd_wr}), 64'd0);
        check({tag, "_din"},  64'(sd_buff_din), 64'd0);
        check({tag, "_busy"}, 64'(busy),        64'd0);
        check({tag, "_gnt"},  64'(grant),       64'd0);
        check({tag, "_to"},   64'(timeout),     64'd0);
    endtask

    // One full transfer, starting and ending in IDLE. Requests are sampled at the grant edge.
    task automatic run_txn(input int nbytes, input bit withdraw, output int g);
        logic [N-1:0] pend, oh;
        logic         dir;
        logic [31:0]  lba;
        logic [7:0]   din;
        int           wait_c;
        pend = req_rd | req_wr;
        g    = model_pick(pend, ptr_m);
        dir  = req_wr[g];
        lba  = req_lba[g];
        din  = req_buff_din[g];
        oh   = 4'b0001 << g;
        tick();
        check("grant", 64'(grant), 64'(g));
        check("sd_lba", 64'(sd_lba), 64'(lba));
        check("busy_issue", 64'(busy), 64'd1);
        check("rdwr_not_yet", 64'({sd_rd, sd_wr}), 64'd0);
        if (withdraw) begin
            req_rd = '0;
            req_wr = '0;
        end
        tick();
        check("rdwr_dir", 64'({sd_rd, sd_wr}), 64'({~dir, dir}));
        check("din_issue", 64'(sd_buff_din), 64'(din));
        wait_c = $urandom_range(0, 3);
        repeat (wait_c) begin
            tick();
            check("rdwr_hold", 64'({sd_rd, sd_wr}), 64'({~dir, dir}));
        end
        sd_ack = 1'b1;
        tick();
        check("rdwr_drop", 64'({sd_rd, sd_wr}), 64'd0);
        for (int b = 0; b < nbytes; b++) begin
            sd_buff_wr = 1'b1;
            #1;
            check("buff_wr_route", 64'(req_buff_wr), 64'(oh));
            check("ack_route", 64'(req_ack), 64'(oh));
            check("din_xfer", 64'(sd_buff_din), 64'(din));
            sd_buff_wr = 1'b0;
            tick();
            check("buff_wr_low", 64'(req_buff_wr), 64'd0);
        end
        sd_ack = 1'b0;
        #1;
        check("ack_low", 64'(req_ack), 64'd0);
        tick();
        check("busy_done", 64'(busy), 64'd1);
        check("lba_hold", 64'(sd_lba), 64'(lba));
        ptr_m = (g + 1) % N;
        tick();
        check("busy_idle", 64'(busy), 64'd0);
        check("grant_hold", 64'(grant), 64'(g));
        check("timeout_low", 64'(timeout), 64'd0);
    endtask

    initial begin
        int g;
        int n;
        bit seen;

        RESET        = 1'b1;
        req_rd       = '0;
        req_wr       = '0;
        req_lba      = '0;
        req_buff_din = '0;
        sd_ack       = 1'b0;
        sd_buff_wr   = 1'b0;
        #12;
        check_all_zero("reset");
        RESET = 1'b0;
        tick();

        // sd_ack/sd_buff_wr while IDLE must not reach any drive.
        sd_ack     = 1'b1;
        sd_buff_wr = 1'b1;
        #1;
        check("idle_ack", 64'(req_ack), 64'd0);
        check("idle_bwr", 64'(req_buff_wr), 64'd0);
        tick();
        check("idle_busy", 64'(busy), 64'd0);
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;

        // Single read from drive 2, 256 strobes, request withdrawn after grant.
        req_rd[2]  = 1'b1;
        req_lba[2] = 32'h0000_0123;
        run_txn(256, 1'b1, g);

        // All four reading: fresh pointer gives 0,1,2,3,0.
        RESET = 1'b1;
        #1;
        check("reset2_busy", 64'(busy), 64'd0);
        #2;
        RESET = 1'b0;
        ptr_m = 0;
        req_rd = 4'hF;
        for (int d = 0; d < N; d++) req_lba[d] = 32'h1000 + 32'(d);
        for (int i = 0; i < 5; i++) run_txn(2, 1'b0, g);
        req_rd = '0;

        // Write path on drive 1 with distinct buffer data on drive 0.
        req_wr[1]       = 1'b1;
        req_lba[1]      = 32'hCAFE_0001;
        req_buff_din[1] = 8'hA5;
        req_buff_din[0] = 8'h5A;
        run_txn(4, 1'b1, g);

        // Read and write together on drive 0: write wins.
        req_rd[0] = 1'b1;
        req_wr[0] = 1'b1;
        run_txn(3, 1'b1, g);

        // Reset in the middle of XFER.
        req_rd[1] = 1'b1;
        tick();
        tick();
        sd_ack = 1'b1;
        tick();
        check("xfer_pre_busy", 64'(busy), 64'd1);
        sd_buff_wr = 1'b1;
        #1;
        check("xfer_pre_bwr", 64'(req_buff_wr), 64'b0010);
        RESET = 1'b1;
        #1;
        check_all_zero("midreset");
        #2;
        RESET      = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        req_rd     = '0;
        ptr_m      = 0;
        tick();
        check("postreset_busy", 64'(busy), 64'd0);
        req_rd = 4'b0011;
        run_txn(2, 1'b1, g);

`ifdef FDC_ARB_TIMEOUT_EN
        // Drive never acknowledged: watchdog aborts, next pending drive follows.
        req_rd = 4'b1100;
        g = model_pick(req_rd, ptr_m);
        tick();
        check("to_grant", 64'(grant), 64'(g));
        n    = 0;
        seen = 1'b0;
        while (n < 300) begin
            tick();
            n++;
            if (sd_rd) seen = 1'b1;
            else if (seen) break;
        end
        check("to_len", 64'(n), 64'(TB_TIMEOUT));
        check("to_pulse", 64'(timeout), 64'd1);
        check("to_noack", 64'(req_ack), 64'd0);
        req_rd[g] = 1'b0;
        tick();
        check("to_pulse_end", 64'(timeout), 64'd0);
        check("to_idle", 64'(busy), 64'd0);
        ptr_m = (g + 1) % N;
        run_txn(2, 1'b1, g);
`endif

        // Randomized traffic against the round-robin model.
        for (int it = 0; it < 40; it++) begin
            req_rd = 4'($urandom);
            req_wr = 4'($urandom) & 4'($urandom);
            for (int d = 0; d < N; d++) begin
                req_lba[d]      = $urandom;
                req_buff_din[d] = 8'($urandom);
            end
            if ((req_rd | req_wr) == '0) begin
                tick();
                check("rand_idle", 64'(busy), 64'd0);
            end else begin
                run_txn($urandom_range(1, 6), 1'($urandom_range(0, 1)), g);
            end
        end
        req_rd = '0;
        req_wr = '0;
        tick();
        check("final_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
